// File: rtl/chan_scan_mux.sv
// chan_scan_mux: registered NCH-to-1 channel selector.
//
// Picks one of NCH W-bit channels from a flat bus, either under manual
// control (sel/sel_load) or by an automatic round-robin scan that dwells
// DWELL unstalled cycles on each channel. The chosen sample is registered
// behind a valid/ready handshake. The output holds steady under
// back-pressure, and the scan freezes while the output is stalled.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    flat channel bus, channel k at [k*W +: W]
//   in_valid   per-channel valid
//   mode       0 = MANUAL, 1 = SCAN
//   sel        manual channel index
//   sel_load   load sel into the current channel (MANUAL only)
//   out_ready  consumer ready
//   out_data   registered selected data
//   out_ch     channel index that out_data came from
//   out_valid  out_data valid
//   sel_err    one-cycle pulse: an out-of-range sel load was rejected

// Per-channel tap: gates one channel's data and valid onto the shared
// AND-OR select tree when this channel is the current one.
module chan_scan_tap #(
  parameter int W   = 8,
  parameter int SW  = 4,
  parameter int IDX = 0
) (
  input  logic [SW-1:0] cur_ch,
  input  logic [W-1:0]  data,
  input  logic          valid,
  output logic [W-1:0]  gated_data,
  output logic          gated_valid
);
  logic hit;

  assign hit         = (cur_ch == SW'(IDX));
  assign gated_data  = hit ? data : '0;
  assign gated_valid = hit & valid;
endmodule

module chan_scan_mux #(
  parameter int NCH   = 9,
  parameter int W     = 8,
  parameter int DWELL = 4,
  parameter int SW    = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH*W-1:0] in_data,
  input  logic [NCH-1:0]   in_valid,
  input  logic             mode,
  input  logic [SW-1:0]    sel,
  input  logic             sel_load,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [SW-1:0]    out_ch,
  output logic             out_valid,
  output logic             sel_err
);
  localparam int DCW = $clog2(DWELL) + 1;
  // Compare sel one bit wider so that NCH == 2**SW is handled as well.
  localparam logic [SW:0]    NCH_V   = (SW+1)'(NCH);
  localparam logic [SW-1:0]  LAST_CH = SW'(NCH - 1);
  localparam logic [DCW-1:0] LAST_DW = DCW'(DWELL - 1);

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_t;

  state_t              state;
  logic [SW-1:0]       cur_ch;
  logic [DCW-1:0]      dcnt;

  logic [NCH-1:0][W-1:0] ch_data;
  logic [NCH-1:0][W-1:0] tap_data;
  logic [NCH-1:0]        tap_valid;
  logic [W-1:0]          pick_data;
  logic                  pick_valid;

  logic                  stall;
  logic                  sel_ok;
  logic                  dwell_end;
  logic [SW-1:0]         next_ch;

  // The flat bus maps directly onto the packed array: channel k is
  // element k.
  assign ch_data = in_data;

  for (genvar k = 0; k < NCH; k++) begin : g_tap
    chan_scan_tap #(
      .W   (W),
      .SW  (SW),
      .IDX (k)
    ) u_tap (
      .cur_ch      (cur_ch),
      .data        (ch_data[k]),
      .valid       (in_valid[k]),
      .gated_data  (tap_data[k]),
      .gated_valid (tap_valid[k])
    );
  end

  // At most one tap is hit, so OR-ing the gated lanes gives the select.
  always_comb begin
    pick_data = '0;
    for (int k = 0; k < NCH; k++) pick_data |= tap_data[k];
  end
  assign pick_valid = |tap_valid;

  assign stall     = out_valid & ~out_ready;
  assign sel_ok    = {1'b0, sel} < NCH_V;
  assign dwell_end = (dcnt == LAST_DW);
  assign next_ch   = (cur_ch == LAST_CH) ? '0 : cur_ch + SW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= MANUAL;
      cur_ch    <= '0;
      dcnt      <= '0;
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      state   <= state_t'(mode);
      sel_err <= 1'b0;

      case (state)
        MANUAL: begin
          // dcnt parks at 0 here, so entering SCAN starts a fresh dwell
          // on whatever channel is current. Loads are honoured even when
          // the output is stalled.
          dcnt <= '0;
          if (sel_load) begin
            if (sel_ok) cur_ch  <= sel;
            else        sel_err <= 1'b1;
          end
        end
        SCAN: begin
          // The scan only advances on cycles that actually move a sample,
          // so back-pressure never skips a channel or cuts a dwell short.
          if (!stall) begin
            if (dwell_end) begin
              dcnt   <= '0;
              cur_ch <= next_ch;
            end else begin
              dcnt <= dcnt + DCW'(1);
            end
          end
        end
        default: ;
      endcase

      if (!stall) begin
        if (pick_valid) begin
          out_data  <= pick_data;
          out_ch    <= cur_ch;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_chan_scan_mux.sv
// Directed bench for chan_scan_mux (NCH=9, W=8, DWELL=4).
// Expected transfers go into a queue as stimulus is driven. Just before
// each rising edge, any pending handshake (out_valid && out_ready) pops
// the queue and compares the entry with out_ch/out_data.
module tb_chan_scan_mux;
  localparam int NCH   = 9;
  localparam int W     = 8;
  localparam int DWELL = 4;
  localparam int SW    = $clog2(NCH);

  typedef struct packed {
    logic [SW-1:0] ch;
    logic [W-1:0]  data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0]   in_valid;
  logic             mode;
  logic [SW-1:0]    sel;
  logic             sel_load;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [SW-1:0]    out_ch;
  logic             out_valid;
  logic             sel_err;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  chan_scan_mux #(.NCH(NCH), .W(W), .DWELL(DWELL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .mode      (mode),
    .sel       (sel),
    .sel_load  (sel_load),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .sel_err   (sel_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Channel k carries base + k.
  task automatic set_data(input logic [W-1:0] base);
    for (int k = 0; k < NCH; k++) in_data[k*W +: W] = base + W'(k);
  endtask

  // One clock: handshake check at negedge, then return just after posedge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (sb.size() > 0) e = sb.pop_front();
      else               e = 'x;
      chk("sb_xfer", {out_ch, out_data}, e);
    end
    @(posedge clk);
    #1;
  endtask

  // n edges, each of which should register {ch, data} as a valid output.
  task automatic run(input int n, input logic [SW-1:0] ch, input logic [W-1:0] data);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.ch   = ch;
      e.data = data;
      sb.push_back(e);
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; sel = '0; sel_load = 1'b0;
    out_ready = 1'b1; in_valid = '0; set_data(8'hA0);
    step(); step();
    chk("rst_out_data",  out_data,  0);
    chk("rst_out_ch",    out_ch,    0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sel_err",   sel_err,   0);
    rst_n = 1'b1;
    step();
    chk("idle_valid", out_valid, 0);

    // Manual load of channel 5: new channel visible two edges later.
    sel = 4'd5; sel_load = 1'b1; in_valid = '1;
    run(1, 4'd0, 8'hA0);
    sel_load = 1'b0;
    run(1, 4'd5, 8'hA5);
    chk("man_out_ch",    out_ch,    5);
    chk("man_out_data",  out_data,  8'hA5);
    chk("man_out_valid", out_valid, 1);

    // Out-of-range load is rejected with a one-cycle sel_err.
    sel = 4'd12; sel_load = 1'b1;
    run(1, 4'd5, 8'hA5);
    chk("oor_sel_err", sel_err, 1);
    chk("oor_out_ch",  out_ch,  5);
    sel_load = 1'b0;
    run(1, 4'd5, 8'hA5);
    chk("oor_sel_err_drop", sel_err, 0);
    chk("oor_out_ch_hold",  out_ch,  5);

    // Scan from channel 0, channel k data = k, 4 cycles per channel.
    set_data(8'h00); sel = 4'd0; sel_load = 1'b1;
    run(1, 4'd5, 8'h05);
    sel_load = 1'b0; mode = 1'b1;
    run(1, 4'd0, 8'h00);              // last MANUAL edge
    for (int k = 0; k < NCH; k++) begin
      run(DWELL, SW'(k), W'(k));
      chk("scan_ch", out_ch, k);
    end
    run(1, 4'd0, 8'h00);
    chk("scan_wrap", out_ch, 0);

    // Back-pressure mid-dwell (two ch0 cycles used so far); scan-mode
    // sel loads must be ignored meanwhile.
    set_data(8'h40);
    run(1, 4'd0, 8'h40);
    out_ready = 1'b0; set_data(8'h80); sel = 4'd15; sel_load = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_data", out_data, 8'h40);
      chk("bp_ch",   out_ch,   0);
    end
    chk("bp_valid",   out_valid, 1);
    chk("bp_sel_err", sel_err,   0);
    out_ready = 1'b1; sel_load = 1'b0;
    run(2, 4'd0, 8'h80);              // remaining two dwell cycles on ch0
    run(DWELL, 4'd1, 8'h81);

    // Back to MANUAL, park on ch3, then toggle its valid.
    mode = 1'b0;
    run(1, 4'd2, 8'h82);              // still SCAN on this edge
    sel = 4'd3; sel_load = 1'b1;
    run(1, 4'd2, 8'h82);
    sel_load = 1'b0;
    run(1, 4'd3, 8'h83);
    in_valid[3] = 1'b0;
    step();
    chk("iv_drop_valid", out_valid, 0);
    chk("iv_drop_hold",  out_data,  8'h83);
    in_valid[3] = 1'b1;
    run(1, 4'd3, 8'h83);
    chk("iv_rise_valid", out_valid, 1);

    // Async reset in the middle of a stall, then first cycles after it.
    mode = 1'b1;
    run(1, 4'd3, 8'h83);
    out_ready = 1'b0;
    step(); step();
    chk("ar_pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_out_data",  out_data,  0);
    chk("ar_out_ch",    out_ch,    0);
    chk("ar_sel_err",   sel_err,   0);
    sb.delete();                      // the stalled sample never transferred
    step(); step();
    sel = 4'd7; sel_load = 1'b1; out_ready = 1'b1;
    rst_n = 1'b1;
    run(1, 4'd0, 8'h80);              // MANUAL accepts the load, cur_ch was 0
    sel_load = 1'b0;
    run(1, 4'd7, 8'h87);
    in_valid = '0;
    step();
    chk("end_valid",  out_valid, 0);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/chan_scan_mux.md
# chan_scan_mux

Parametrised, registered N-to-1 channel selector: the sequential successor to the team's fixed-width 9:1 combinational mux. Selects one of NCH W-bit input channels, either under manual control or by automatic round-robin scan with a programmable dwell. Output is registered behind a valid/ready handshake, so the block can drive a pipelined consumer without losing samples during back-pressure.

## Interface
- NCH, 9, number of input channels (2..256)
- W, 8, data width per channel
- DWELL, 4, cycles spent on each channel in scan mode (1..65535)
- SW (derived), clog2(NCH), select/channel-index width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset; all state clears immediately on assertion, released synchronously by design integration
- in_data  in  NCH*W  flat channel bus; channel k occupies bits [k*W +: W]
- in_valid  in  NCH  per-channel valid
- mode  in  1  0 = MANUAL, 1 = SCAN
- sel  in  SW  manual channel index
- sel_load  in  1  load sel into current channel (MANUAL only)
- out_ready  in  1  consumer ready
- out_data  out  W  registered selected data
- out_ch  out  SW  channel index that out_data came from
- out_valid  out  1  out_data valid
- sel_err  out  1  one-cycle pulse: out-of-range sel load rejected

## Operation
- Two-state FSM: MANUAL and SCAN, next state = mode, sampled every cycle.
- Internal cur_ch (SW bits) names the selected channel; dwell counter dcnt (clog2(DWELL)+1 bits).
- MANUAL: on sel_load, if sel < NCH, cur_ch <= sel; otherwise cur_ch is held and sel_err = 1 for one cycle. dcnt is held at 0.
- SCAN: sel_load and sel are ignored (sel_err not asserted). dcnt counts 0..DWELL-1; at DWELL-1, dcnt <= 0 and cur_ch <= (cur_ch == NCH-1) ? 0 : cur_ch+1. With DWELL=1, cur_ch advances every unstalled cycle.
- Transition MANUAL->SCAN: dcnt <= 0, cur_ch retained; scan starts from the current channel. Transition SCAN->MANUAL: cur_ch retained.
- Stall = out_valid && !out_ready. During a stall dcnt and cur_ch freeze in SCAN; a manual sel_load is still accepted.
- Output register: when !stall and in_valid[cur_ch], load out_data <= in_data[cur_ch], out_ch <= cur_ch, out_valid <= 1. When !stall and !in_valid[cur_ch], out_valid <= 0 and out_data/out_ch hold.
- During a stall, out_data, out_ch and out_valid hold exactly.

## Timing
- Reset values: out_data=0, out_ch=0, out_valid=0, sel_err=0, cur_ch=0, dcnt=0, FSM=MANUAL.
- Latency: 1 cycle from in_data/in_valid of cur_ch to out_data/out_valid.
- sel_load at cycle t changes cur_ch at t+1. The first sample of the new channel appears on the outputs at t+2.
- sel_err is asserted in cycle t+1 for a bad load at t, and is high for exactly 1 cycle.
- Channel changes in SCAN occur on the edge where dcnt wraps. Each channel is presented for DWELL unstalled cycles.
- Handshake: a transfer occurs on any edge with out_valid && out_ready. out_data must not change while out_valid=1 and out_ready=0.
- Reset assertion mid-stall or mid-dwell clears out_valid combinationally via the async path. No partial transfer is counted.

## Test plan
- Reset then MANUAL: sel_load sel=5, in_data ch5=0xA5, in_valid all 1, out_ready=1 -> out_data=0xA5, out_ch=5, out_valid=1 at load+2 cycles.
- Out-of-range: NCH=9, sel_load sel=12 -> sel_err pulses 1 cycle, cur_ch and out_ch unchanged.
- SCAN, DWELL=4, all valid, channel k data = k -> out_ch sequence is 0,0,0,0,1,…,8,8,8,8,0: wraps after ch8, and each value appears for 4 cycles.
- Back-pressure: SCAN, hold out_ready=0 for 10 cycles mid-dwell -> out_data/out_ch frozen, and after release the dwell resumes at the frozen count with no channel skipped.
- Invalid channel: MANUAL ch3, drop in_valid[3] with out_ready=1 -> out_valid=0 next cycle. Re-raise in_valid[3] -> out_valid=1 one cycle later.
- Async reset asserted during a stall with out_valid=1 -> all outputs 0 immediately. After release, FSM=MANUAL and cur_ch=0.
